// File: rtl/struct_field_arbiter.sv
// Round-robin arbiter granting field-granular access to a packed {flag, value, tag} register.
// Optional STRUCT_ARB_LOCK_EN adds a per-requester lock that keeps the grant across back-to-back accesses.
module struct_field_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned VALUE_W = 32,
    parameter int unsigned TAG_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         we,
    input  logic [2*NUM_REQ-1:0]       field_sel,
    input  logic [VALUE_W*NUM_REQ-1:0] wdata,
`ifdef STRUCT_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         lock,
`endif
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         ack,
    output logic [VALUE_W-1:0]         rdata,
    output logic                       busy,
    output logic [VALUE_W+TAG_W:0]     struct_out
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic               flag;
        logic [VALUE_W-1:0] value;
        logic [TAG_W-1:0]   tag;
    } fields_t;

    typedef enum logic [1:0] {
        F_FLAG,
        F_VALUE,
        F_TAG,
        F_RSVD
    } field_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RELEASE
`ifdef STRUCT_ARB_LOCK_EN
        , S_LOCKED
`endif
    } state_t;

    state_t             state, state_d;
    fields_t            fields_q, fields_d;
    logic [NUM_REQ-1:0] gnt_d, ack_d;
    logic [VALUE_W-1:0] rdata_d;
    logic               busy_d;
    logic [IDX_W-1:0]   winner, winner_d;
    logic [IDX_W-1:0]   rr_ptr, rr_d;
    logic               served, served_d;
    logic [IDX_W-1:0]   pick, cand;
    logic               found;

    logic [1:0]         sel_a [NUM_REQ];
    logic [VALUE_W-1:0] wd_a  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign sel_a[g] = field_sel[2*g +: 2];
        assign wd_a[g]  = wdata[VALUE_W*g +: VALUE_W];
    end

    assign struct_out = fields_q;

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        pick  = rr_ptr;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state;
        gnt_d    = gnt;
        ack_d    = '0;
        rdata_d  = rdata;
        busy_d   = busy;
        fields_d = fields_q;
        winner_d = winner;
        rr_d     = rr_ptr;
        served_d = served;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    winner_d    = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    busy_d      = 1'b1;
                    served_d    = 1'b0;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_RELEASE;
                if (req[winner]) begin
                    served_d      = 1'b1;
                    ack_d[winner] = 1'b1;
                    if (we[winner]) begin
                        case (field_t'(sel_a[winner]))
                            F_FLAG:  fields_d.flag  = wd_a[winner][0];
                            F_VALUE: fields_d.value = wd_a[winner];
                            F_TAG:   fields_d.tag   = wd_a[winner][TAG_W-1:0];
                            default: ;
                        endcase
                    end else begin
                        case (field_t'(sel_a[winner]))
                            F_FLAG:  rdata_d = VALUE_W'(fields_q.flag);
                            F_VALUE: rdata_d = fields_q.value;
                            F_TAG:   rdata_d = VALUE_W'(fields_q.tag);
                            default: rdata_d = '0;
                        endcase
                    end
`ifdef STRUCT_ARB_LOCK_EN
                    if (lock[winner]) state_d = S_LOCKED;
`endif
                end
            end
            S_RELEASE: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (served) rr_d = (32'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
            end
`ifdef STRUCT_ARB_LOCK_EN
            S_LOCKED: begin
                if (req[winner])       state_d = S_ACCESS;
                else if (!lock[winner]) state_d = S_RELEASE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            gnt      <= '0;
            ack      <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            fields_q <= '0;
            winner   <= '0;
            rr_ptr   <= '0;
            served   <= 1'b0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            ack      <= ack_d;
            rdata    <= rdata_d;
            busy     <= busy_d;
            fields_q <= fields_d;
            winner   <= winner_d;
            rr_ptr   <= rr_d;
            served   <= served_d;
        end
    end

endmodule

// File: tb/tb_struct_field_arbiter.sv
// Directed bench for struct_field_arbiter; expected accesses are queued at issue and checked on ack.
module tb_struct_field_arbiter;

    localparam int unsigned N = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   we = '0;
    logic [2*N-1:0] field_sel = '0;
    logic [32*N-1:0] wdata = '0;
`ifdef STRUCT_ARB_LOCK_EN
    logic [N-1:0]   lock = '0;
`endif
    logic [N-1:0]   gnt, ack;
    logic [31:0]    rdata;
    logic           busy;
    logic [40:0]    struct_out;

    typedef struct {
        int          who;
        bit          wr;
        logic [31:0] rd;
        logic [40:0] st;
    } exp_t;

    exp_t        sb[$];
    logic [40:0] m = '0;
    int          passed = 0;
    int          failed = 0;
    int          total = 0;

    struct_field_arbiter #(.NUM_REQ(N), .VALUE_W(32), .TAG_W(8)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .field_sel(field_sel), .wdata(wdata),
`ifdef STRUCT_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .struct_out(struct_out)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(int i, bit w, logic [1:0] s, logic [31:0] d);
        we[i] = w;
        field_sel[2*i +: 2] = s;
        wdata[32*i +: 32] = d;
    endtask

    // Reference model: {flag, value, tag} kept as a flat 41-bit vector.
    function automatic void push_exp(int i, bit w, logic [1:0] s, logic [31:0] d);
        exp_t e;
        e.who = i;
        e.wr  = w;
        e.rd  = '0;
        if (w) begin
            case (s)
                2'd0: m[40] = d[0];
                2'd1: m[39:8] = d;
                2'd2: m[7:0] = d[7:0];
                default: ;
            endcase
        end else begin
            case (s)
                2'd0: e.rd = {31'b0, m[40]};
                2'd1: e.rd = m[39:8];
                2'd2: e.rd = {24'b0, m[7:0]};
                default: e.rd = '0;
            endcase
        end
        e.st = m;
        sb.push_back(e);
    endfunction

    task automatic wait_ack(int i, string name);
        bit seen = 1'b0;
        for (int n = 0; n < 16 && !seen; n++) begin
            tick();
            seen = ack[i];
        end
        check(name, 64'(seen), 64'(1));
    endtask

    task automatic serve(int i, bit w, logic [1:0] s, logic [31:0] d, string name);
        set_in(i, w, s, d);
        push_exp(i, w, s, d);
        req[i] = 1'b1;
        wait_ack(i, name);
        req[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && ack !== '0) begin
            if (sb.size() == 0) begin
                check("spurious_ack", 64'(ack), 64'(0));
            end else begin
                e = sb.pop_front();
                check("ack_who", 64'(ack), 64'(1) << e.who);
                if (!e.wr) check("rdata", 64'(rdata), 64'(e.rd));
                check("struct", 64'(struct_out), 64'(e.st));
            end
        end
    end

    initial begin
        // reset state
        tick(); tick(); tick();
        check("rst_struct", 64'(struct_out), 64'(0));
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_ack", 64'(ack), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        reset = 1'b1;
        tick();

        // requester 0 writes value 100, with cycle-exact handshake
        set_in(0, 1'b1, 2'd1, 32'd100);
        push_exp(0, 1'b1, 2'd1, 32'd100);
        req[0] = 1'b1;
        tick();
        check("w0_gnt", 64'(gnt), 64'(2'b01));
        check("w0_busy", 64'(busy), 64'(1));
        check("w0_ack_early", 64'(ack), 64'(0));
        tick();
        check("w0_ack", 64'(ack), 64'(2'b01));
        check("w0_struct", 64'(struct_out), 64'(41'd100 << 8));
        req[0] = 1'b0;
        tick();
        check("w0_gnt_low", 64'(gnt), 64'(0));
        check("w0_ack_low", 64'(ack), 64'(0));
        check("w0_busy_low", 64'(busy), 64'(0));

        // requester 1 writes tag then reads value
        serve(1, 1'b1, 2'd2, 32'd10, "w1_tag");
        check("w1_struct", 64'(struct_out), 64'(41'h640A));
        serve(1, 1'b0, 2'd1, 32'd0, "r1_value");
        tick(); tick();
        check("r1_hold", 64'(rdata), 64'(100));
        check("r1_struct", 64'(struct_out), 64'(41'h640A));

        // simultaneous requests after reset; requester 0 re-requests immediately
        reset = 1'b0;
        m = '0;
        tick();
        reset = 1'b1;
        set_in(0, 1'b1, 2'd2, 32'h11);
        set_in(1, 1'b1, 2'd2, 32'h22);
        push_exp(0, 1'b1, 2'd2, 32'h11);
        push_exp(1, 1'b1, 2'd2, 32'h22);
        req = 2'b11;
        tick();
        check("rr_first", 64'(gnt), 64'(2'b01));
        wait_ack(0, "rr_ack0");
        set_in(0, 1'b1, 2'd1, 32'h0BAD);
        push_exp(0, 1'b1, 2'd1, 32'h0BAD);
        wait_ack(1, "rr_ack1");
        req[1] = 1'b0;
        wait_ack(0, "rr_ack0b");
        req[0] = 1'b0;

        // flag uses bit 0 only; reserved field
        serve(0, 1'b1, 2'd0, 32'hFFFF_FFFE, "flag_even");
        serve(0, 1'b0, 2'd0, 32'd0, "flag_rd0");
        serve(0, 1'b1, 2'd0, 32'd1, "flag_one");
        serve(1, 1'b0, 2'd0, 32'd0, "flag_rd1");
        check("flag_rdata", 64'(rdata), 64'(1));
        serve(1, 1'b0, 2'd3, 32'd0, "rsvd_rd");
        check("rsvd_rdata", 64'(rdata), 64'(0));
        serve(0, 1'b1, 2'd3, 32'hDEAD_BEEF, "rsvd_wr");
        serve(1, 1'b0, 2'd2, 32'd0, "tag_rd");

        // reset during ACCESS of a value write
        tick(); tick();
        set_in(0, 1'b1, 2'd1, 32'd200);
        req[0] = 1'b1;
        tick();
        check("mid_gnt", 64'(gnt), 64'(2'b01));
        reset = 1'b0;
        m = '0;
        #1;
        check("mid_struct", 64'(struct_out), 64'(0));
        check("mid_gnt0", 64'(gnt), 64'(0));
        check("mid_ack0", 64'(ack), 64'(0));
        check("mid_busy0", 64'(busy), 64'(0));
        req[0] = 1'b0;
        tick(); tick();
        check("mid_ack_none", 64'(ack), 64'(0));
        reset = 1'b1;
        set_in(1, 1'b1, 2'd1, 32'd5);
        push_exp(1, 1'b1, 2'd1, 32'd5);
        req[1] = 1'b1;
        tick();
        check("post_rst_gnt", 64'(gnt), 64'(2'b10));
        wait_ack(1, "post_rst_ack");
        req[1] = 1'b0;
        tick(); tick();

`ifdef STRUCT_ARB_LOCK_EN
        begin
            int gap;
            bit g1_early = 1'b0;
            set_in(0, 1'b1, 2'd1, 32'd1);
            set_in(1, 1'b1, 2'd2, 32'h5A);
            push_exp(0, 1'b1, 2'd1, 32'd1);
            lock[0] = 1'b1;
            req = 2'b11;
            wait_ack(0, "lock_ack1");
            for (int k = 2; k <= 3; k++) begin
                set_in(0, 1'b1, 2'd1, 32'(k));
                push_exp(0, 1'b1, 2'd1, 32'(k));
                gap = 0;
                do begin
                    tick();
                    gap++;
                    if (gnt[1]) g1_early = 1'b1;
                end while (!ack[0] && gap < 8);
                check("lock_gap", 64'(gap), 64'(2));
            end
            push_exp(1, 1'b1, 2'd2, 32'h5A);
            req[0] = 1'b0;
            lock[0] = 1'b0;
            check("lock_no_gnt1", 64'(g1_early), 64'(0));
            wait_ack(1, "lock_then_1");
            req[1] = 1'b0;
            tick(); tick();
        end
`endif

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
